multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM that sequences the shared-ALU/shared-memory MIPS multicycle datapath.
//  Instruction is the IR output. The block drives all datapath enables and muxes plus ALUControl.
//  Memory accesses stall on a MemReady handshake. Illegal opcode/funct or memory timeout -> sticky Trap.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles in one memory-wait state before Trap (>=2)
// PORTS
//  Clk          in   1   clock, all state updates on posedge
//  Rst          in   1   synchronous, active-low reset
//  Instruction  in   32  IR contents; [31:26] opcode, [5:0] funct; valid from DECODE on
//  Zero         in   1   ALU zero flag
//  MemReady     in   1   memory completes current read/write this cycle
//  PCEn         out  1   PC write enable (uncond | BRANCH&Zero)
//  PCSource     out  2   00 ALU result, 01 ALUOut (branch target), 10 jump addr
//  IorD         out  1   0 PC addr, 1 ALUOut addr
//  MemRead      out  1   memory read strobe, held until MemReady
//  MemWrite     out  1   memory write strobe, held until MemReady
//  IRWrite      out  1   IR load
//  RegDst       out  1   1 rd, 0 rt
//  MemtoReg     out  1   1 MDR, 0 ALUOut
//  RegWrite     out  1   register file write
//  ALUSrcA      out  1   0 PC, 1 rs
//  ALUSrcB      out  2   00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
//  ALUOp        out  2   00 add, 01 sub, 10 funct
//  ALUControl   out  3   010 add,110 sub,000 and,001 or,111 slt
//  InstrDone    out  1   1-cycle pulse in last state of each instruction
//  Trap         out  1   sticky error flag; cleared only by reset
// BEHAVIOUR
//  Reset (Rst=0 at posedge): state<=FETCH, wait counter<=0, Trap<=0.
//  While Rst=0, all outputs are forced to 0, including the enables and ALUControl.
//  Unlisted outputs are 0 in each state. Next-state follows the arrow.
//  FETCH: MemRead, ALUSrcB=01, ALUOp=00, IRWrite=PCEn=MemReady. Holds while !MemReady; ->DECODE.
//  DECODE: ALUSrcB=11, ALUOp=00. Decode 000000 R-type:
//    funct in {100000,100010,100100,100101,101010} ->EXEC_R, else ->TRAP.
//    100011 lw / 101011 sw ->MEM_ADDR; 000100 beq ->BRANCH; 000010 j ->JUMP;
//    001000 addi ->EXEC_I; any other opcode ->TRAP.
//  EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 ->WB_R.
//  WB_R: RegDst, RegWrite, InstrDone ->FETCH.
//  EXEC_I: ALUSrcA=1, ALUSrcB=10 ->WB_I.
//  WB_I: RegWrite, InstrDone ->FETCH.
//  MEM_ADDR: ALUSrcA=1, ALUSrcB=10 -> MEM_RD (lw) / MEM_WR (sw).
//  MEM_RD: MemRead, IorD. Holds while !MemReady; ->WB_LW.
//  WB_LW: MemtoReg, RegWrite, InstrDone ->FETCH.
//  MEM_WR: MemWrite, IorD, InstrDone=MemReady. Holds while !MemReady; ->FETCH.
//  BRANCH: ALUSrcA=1, ALUOp=01, PCSource=01, PCEn=Zero, InstrDone ->FETCH.
//  JUMP: PCSource=10, PCEn=1, InstrDone ->FETCH.
//  TRAP: Trap=1, all enables 0; absorbing until reset.
//  Latency with MemReady tied to 1:
//    beq/j 3; R/addi/sw 4; lw 5 cycles FETCH-to-FETCH.
//    Each MemReady=0 cycle adds 1.
//  Wait counter: increments each cycle in FETCH/MEM_RD/MEM_WR with MemReady=0.
//    Clears on any state change.
//    Counter==MEM_TIMEOUT-1 with MemReady=0 -> TRAP next cycle; no strobe follows.
//    MemReady=1 on the timeout cycle wins: normal transition.
//  ALUControl:
//    ALUOp=00 -> 010; ALUOp=01 -> 110.
//    ALUOp=10 -> funct map (100000->010, 100010->110, 100100->000, 100101->001, 101010->111).
//    Unmapped funct -> 010 (never reached; DECODE traps).
//  Rst=0 mid-instruction, e.g. during a MEM_WR stall: strobes drop in the same cycle.
//    FETCH at the next edge.
// STRUCTURE
//  Package mips_ctrl_pkg: state encodings (4-bit localparams), opcode/funct constants,
//    ALUOp and ALUControl codes.
//  Sub-module alu_control (combinational ALUOp+funct -> ALUControl), instantiated once.
//  Top: state register, wait counter, next-state logic, Moore output decode.
// TESTING
//  1 add 000000_00001_00010_00011_00000_100000, MemReady=1:
//    states F,D,EXEC_R,WB_R; ALUControl=010 in EXEC_R; RegWrite=1, RegDst=1 in WB_R;
//    InstrDone pulse at cycle 4.
//  2 lw 100011_00001_00010_0x0000, MemReady low 3 cycles in MEM_RD:
//    MemRead=IorD=1 held 4 cycles; WB_LW MemtoReg=RegWrite=1; 8 cycles total.
//  3 beq 000100_...0x0004 with Zero=1, then Zero=0:
//    BRANCH ALUControl=110, PCSource=01; PCEn=1 then PCEn=0; 3 cycles each.
//  4 sw with MemReady=0 for MEM_TIMEOUT=16 cycles:
//    MemWrite high 16 cycles, then Trap=1 sticky, all enables 0.
//    Rst=0 clears Trap and re-enters FETCH.
//  5 Opcode 111111, then R-type funct 000000:
//    each -> TRAP one cycle after DECODE; RegWrite never asserted.
//  6 Rst=0 during MEM_WR stall:
//    MemWrite=0 same cycle; after release FETCH with MemRead=1, ALUSrcB=01.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - state, opcode, funct and ALU code definitions for the multicycle controller
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_LW    = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  // R-type funct codes the datapath can execute; anything else traps in DECODE
  function automatic logic is_legal_funct(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

endpackage

// File: rtl/alu_control.sv
// rtl/alu_control.sv - maps ALUOp and funct to the 3-bit ALU operation select
module alu_control
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctl
);

  // Fixed add/sub for address and branch math, funct decode for R-type execution
  always_comb begin
    alu_ctl = ALUC_ADD;
    if (alu_op == ALUOP_SUB) begin
      alu_ctl = ALUC_SUB;
    end else if (alu_op == ALUOP_FUNCT) begin
      case (funct)
        FN_ADD:  alu_ctl = ALUC_ADD;
        FN_SUB:  alu_ctl = ALUC_SUB;
        FN_AND:  alu_ctl = ALUC_AND;
        FN_OR:   alu_ctl = ALUC_OR;
        FN_SLT:  alu_ctl = ALUC_SLT;
        default: alu_ctl = ALUC_ADD;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing the multicycle MIPS datapath
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Instruction,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCEn,
  output logic [1:0]  PCSource,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [2:0]  ALUControl,
  output logic        InstrDone,
  output logic        Trap
);

  localparam int CW = $clog2(MEM_TIMEOUT);

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          mem_wait_state;
  logic          timeout;
  logic [2:0]    alu_ctl_raw;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          instr_unused;

  assign opcode       = Instruction[31:26];
  assign funct        = Instruction[5:0];
  assign instr_unused = ^Instruction[25:6];

  assign mem_wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign timeout        = mem_wait_state && !MemReady && (wait_cnt == CW'(MEM_TIMEOUT - 1));

  alu_control u_alu_control (
    .alu_op  (ALUOp),
    .funct   (funct),
    .alu_ctl (alu_ctl_raw)
  );

  // State register and memory-wait counter; counter restarts whenever the state moves
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if (mem_wait_state && !MemReady) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Next-state: memory states hold until MemReady, or trap once the wait budget is spent
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (MemReady)     state_next = S_DECODE;
        else if (timeout) state_next = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_next = is_legal_funct(funct) ? S_EXEC_R : S_TRAP;
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_EXEC_I;
          default:      state_next = S_TRAP;
        endcase
      end
      S_EXEC_R:   state_next = S_WB_R;
      S_WB_R:     state_next = S_FETCH;
      S_EXEC_I:   state_next = S_WB_I;
      S_WB_I:     state_next = S_FETCH;
      S_MEM_ADDR: state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (MemReady)     state_next = S_WB_LW;
        else if (timeout) state_next = S_TRAP;
      end
      S_WB_LW:    state_next = S_FETCH;
      S_MEM_WR: begin
        if (MemReady)     state_next = S_FETCH;
        else if (timeout) state_next = S_TRAP;
      end
      S_BRANCH:   state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_TRAP;
    endcase
  end

  // Output decode per state; everything is held low while reset is asserted
  always_comb begin
    PCEn       = 1'b0;
    PCSource   = 2'b00;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = ALUOP_ADD;
    InstrDone  = 1'b0;
    Trap       = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCEn    = MemReady;
      end
      S_DECODE:   ALUSrcB = 2'b11;
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_WB_R: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_WB_I: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_WB_LW: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = MemReady;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUOp     = ALUOP_SUB;
        PCSource  = 2'b01;
        PCEn      = Zero;
        InstrDone = 1'b1;
      end
      S_JUMP: begin
        PCSource  = 2'b10;
        PCEn      = 1'b1;
        InstrDone = 1'b1;
      end
      S_TRAP:     Trap = 1'b1;
      default:    Trap = 1'b1;
    endcase
    ALUControl = alu_ctl_raw;
    if (!Rst) begin
      PCEn       = 1'b0;
      PCSource   = 2'b00;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      ALUControl = 3'b000;
      InstrDone  = 1'b0;
      Trap       = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] Instruction;
  logic        Zero;
  logic        MemReady;
  logic        PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic        InstrDone, Trap;
  logic [1:0]  PCSource, ALUSrcB, ALUOp;
  logic [2:0]  ALUControl;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  multicycle_controller #(.MEM_TIMEOUT(16)) dut (
    .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .Zero(Zero), .MemReady(MemReady),
    .PCEn(PCEn), .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ALUControl(ALUControl),
    .InstrDone(InstrDone), .Trap(Trap)
  );

  logic [19:0] outv;
  assign outv = {PCEn, PCSource, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                 RegWrite, ALUSrcA, ALUSrcB, ALUOp, ALUControl, InstrDone, Trap};

  localparam logic [19:0] PCEN    = 20'd1 << 19;
  localparam logic [19:0] PCS_BR  = 20'd1 << 17;
  localparam logic [19:0] PCS_J   = 20'd2 << 17;
  localparam logic [19:0] IORD    = 20'd1 << 16;
  localparam logic [19:0] MRD     = 20'd1 << 15;
  localparam logic [19:0] MWR     = 20'd1 << 14;
  localparam logic [19:0] IRW     = 20'd1 << 13;
  localparam logic [19:0] RDST    = 20'd1 << 12;
  localparam logic [19:0] M2R     = 20'd1 << 11;
  localparam logic [19:0] RW      = 20'd1 << 10;
  localparam logic [19:0] ASA     = 20'd1 << 9;
  localparam logic [19:0] ASB_4   = 20'd1 << 7;
  localparam logic [19:0] ASB_IMM = 20'd2 << 7;
  localparam logic [19:0] ASB_SH  = 20'd3 << 7;
  localparam logic [19:0] AOP_SUB = 20'd1 << 5;
  localparam logic [19:0] AOP_F   = 20'd2 << 5;
  localparam logic [19:0] AC_ADD  = 20'd2 << 2;
  localparam logic [19:0] AC_SUB  = 20'd6 << 2;
  localparam logic [19:0] AC_AND  = 20'd0 << 2;
  localparam logic [19:0] AC_OR   = 20'd1 << 2;
  localparam logic [19:0] AC_SLT  = 20'd7 << 2;
  localparam logic [19:0] DONE    = 20'd1 << 1;
  localparam logic [19:0] TRP     = 20'd1;

  localparam logic [19:0] E_FSTALL = MRD | ASB_4 | AC_ADD;
  localparam logic [19:0] E_FRDY   = E_FSTALL | PCEN | IRW;
  localparam logic [19:0] E_DEC    = ASB_SH | AC_ADD;
  localparam logic [19:0] E_WBR    = RDST | RW | DONE | AC_ADD;
  localparam logic [19:0] E_EXI    = ASA | ASB_IMM | AC_ADD;
  localparam logic [19:0] E_WBI    = RW | DONE | AC_ADD;
  localparam logic [19:0] E_MRD    = MRD | IORD | AC_ADD;
  localparam logic [19:0] E_WBLW   = M2R | RW | DONE | AC_ADD;
  localparam logic [19:0] E_MWR    = MWR | IORD | AC_ADD;
  localparam logic [19:0] E_BR     = ASA | AOP_SUB | AC_SUB | PCS_BR | DONE;
  localparam logic [19:0] E_JMP    = PCS_J | PCEN | DONE | AC_ADD;
  localparam logic [19:0] E_TRAP   = TRP | AC_ADD;

  task automatic do_reset;
    Rst = 1'b0;
    MemReady = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b1;
  endtask

  task automatic test_reset;
    Rst = 1'b0; MemReady = 1'b1; Zero = 1'b1; Instruction = 32'h0;
    repeat (2) @(posedge Clk);
    #2;
    tests++;
    if (outv !== 20'h0) begin fails++; $display("FAIL reset_outputs got %h exp %h", outv, 20'h0); end
    Rst = 1'b1; MemReady = 1'b0; Zero = 1'b0; #1;
    tests++;
    if (outv !== E_FSTALL) begin fails++; $display("FAIL reset_fetch got %h exp %h", outv, E_FSTALL); end
    do_reset();
  endtask

  task automatic test_add;
    logic [19:0] ex[$];
    logic        mr[$];
    Instruction = 32'h0022_1820;
    ex = '{E_FRDY, E_DEC, ASA | AOP_F | AC_ADD, E_WBR, E_FSTALL};
    mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < ex.size(); i++) begin
      MemReady = mr[i]; #1;
      tests++;
      if (outv !== ex[i]) begin fails++; $display("FAIL add cyc%0d got %h exp %h", i, outv, ex[i]); end
      @(posedge Clk); #1;
    end
    do_reset();
  endtask

  task automatic test_r_funct;
    logic [5:0]  fn[4];
    logic [19:0] ac[4];
    fn = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
    ac = '{AC_SUB, AC_AND, AC_OR, AC_SLT};
    for (int k = 0; k < 4; k++) begin
      Instruction = {26'h0022_18 >> 0, fn[k]};
      Instruction[31:26] = 6'b000000;
      MemReady = 1'b1;
      repeat (2) begin @(posedge Clk); #1; end
      #1;
      tests++;
      if (outv !== (ASA | AOP_F | ac[k]))
        begin fails++; $display("FAIL rfunct%0d exec got %h exp %h", k, outv, ASA | AOP_F | ac[k]); end
      repeat (2) begin @(posedge Clk); #1; end
    end
  endtask

  task automatic test_addi;
    logic [19:0] ex[$];
    Instruction = 32'h2022_0005;
    MemReady = 1'b1;
    ex = '{E_FRDY, E_DEC, E_EXI, E_WBI};
    for (int i = 0; i < ex.size(); i++) begin
      #1;
      tests++;
      if (outv !== ex[i]) begin fails++; $display("FAIL addi cyc%0d got %h exp %h", i, outv, ex[i]); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_lw_stall;
    logic [19:0] ex[$];
    logic        mr[$];
    Instruction = 32'h8C22_0000;
    ex = '{E_FRDY, E_DEC, E_EXI, E_MRD, E_MRD, E_MRD, E_MRD, E_WBLW, E_FSTALL};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < ex.size(); i++) begin
      MemReady = mr[i]; #1;
      tests++;
      if (outv !== ex[i]) begin fails++; $display("FAIL lw cyc%0d got %h exp %h", i, outv, ex[i]); end
      @(posedge Clk); #1;
    end
    do_reset();
  endtask

  task automatic test_branch;
    Instruction = 32'h1022_0004;
    MemReady = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      Zero = 1'(z);
      for (int i = 0; i < 3; i++) begin
        logic [19:0] e;
        e = (i == 0) ? E_FRDY : (i == 1) ? E_DEC : (E_BR | (z == 1 ? PCEN : 20'h0));
        #1;
        tests++;
        if (outv !== e) begin fails++; $display("FAIL beq_z%0d cyc%0d got %h exp %h", z, i, outv, e); end
        @(posedge Clk); #1;
      end
    end
    Zero = 1'b0;
  endtask

  task automatic test_jump_fetch_stall;
    logic [19:0] ex[$];
    logic        mr[$];
    Instruction = 32'h0800_0010;
    ex = '{E_FSTALL, E_FSTALL, E_FRDY, E_DEC, E_JMP, E_FSTALL};
    mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < ex.size(); i++) begin
      MemReady = mr[i]; #1;
      tests++;
      if (outv !== ex[i]) begin fails++; $display("FAIL jump cyc%0d got %h exp %h", i, outv, ex[i]); end
      @(posedge Clk); #1;
    end
    do_reset();
  endtask

  task automatic test_sw_timeout;
    logic [19:0] ex[$];
    logic        mr[$];
    Instruction = 32'hAC22_0000;
    ex = '{E_FRDY, E_DEC, E_EXI};
    mr = '{1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 16; k++) begin ex.push_back(E_MWR); mr.push_back(1'b0); end
    ex.push_back(E_TRAP); mr.push_back(1'b0);
    ex.push_back(E_TRAP); mr.push_back(1'b1);
    ex.push_back(E_TRAP); mr.push_back(1'b1);
    for (int i = 0; i < ex.size(); i++) begin
      MemReady = mr[i]; #1;
      tests++;
      if (outv !== ex[i]) begin fails++; $display("FAIL sw_timeout cyc%0d got %h exp %h", i, outv, ex[i]); end
      @(posedge Clk); #1;
    end
    do_reset();
    MemReady = 1'b0; #1;
    tests++;
    if (outv !== E_FSTALL) begin fails++; $display("FAIL trap_clear got %h exp %h", outv, E_FSTALL); end
    do_reset();
  endtask

  task automatic test_timeout_boundary;
    logic [19:0] ex[$];
    logic        mr[$];
    Instruction = 32'hAC22_0000;
    ex = '{E_FRDY, E_DEC, E_EXI};
    mr = '{1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 15; k++) begin ex.push_back(E_MWR); mr.push_back(1'b0); end
    ex.push_back(E_MWR | DONE); mr.push_back(1'b1);
    ex.push_back(E_FSTALL);     mr.push_back(1'b0);
    for (int i = 0; i < ex.size(); i++) begin
      MemReady = mr[i]; #1;
      tests++;
      if (outv !== ex[i]) begin fails++; $display("FAIL sw_boundary cyc%0d got %h exp %h", i, outv, ex[i]); end
      @(posedge Clk); #1;
    end
    do_reset();
  endtask

  task automatic test_illegal;
    logic [31:0] ins[2];
    ins = '{32'hFC00_0000, 32'h0022_1800};
    for (int k = 0; k < 2; k++) begin
      Instruction = ins[k];
      for (int i = 0; i < 4; i++) begin
        logic [19:0] e;
        e = (i == 0) ? E_FRDY : (i == 1) ? E_DEC : E_TRAP;
        MemReady = 1'b1; #1;
        tests++;
        if (outv !== e) begin fails++; $display("FAIL illegal%0d cyc%0d got %h exp %h", k, i, outv, e); end
        @(posedge Clk); #1;
      end
      do_reset();
    end
  endtask

  task automatic test_reset_mid_write;
    Instruction = 32'hAC22_0000;
    MemReady = 1'b1;
    repeat (3) begin @(posedge Clk); #1; end
    MemReady = 1'b0;
    repeat (2) begin @(posedge Clk); #1; end
    #1;
    tests++;
    if (outv !== E_MWR) begin fails++; $display("FAIL midrst_stall got %h exp %h", outv, E_MWR); end
    Rst = 1'b0; #1;
    tests++;
    if (outv !== 20'h0) begin fails++; $display("FAIL midrst_drop got %h exp %h", outv, 20'h0); end
    @(posedge Clk); #1;
    Rst = 1'b1; #1;
    tests++;
    if (outv !== E_FSTALL) begin fails++; $display("FAIL midrst_fetch got %h exp %h", outv, E_FSTALL); end
  endtask

  initial begin
    Rst = 1'b0; Zero = 1'b0; MemReady = 1'b0; Instruction = 32'h0;
    test_reset();
    test_add();
    test_r_funct();
    test_addi();
    test_lw_stall();
    test_branch();
    test_jump_fetch_stall();
    test_sw_timeout();
    test_timeout_boundary();
    test_illegal();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
